mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit for the RV32M subset.
- Consumes the two register-file read operands and returns one result, with its destination address, to the register-file write port.
- Sits beside the single-cycle ALU in the execute stage.
- Uses a start/busy/done handshake so the core stalls while an operation is in flight.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 5, width of the iteration counter; XLEN iterations are counted 0..XLEN-1.

Ports:
- RESET  in  1  asynchronous, active-high reset
- CLK  in  1  clock, rising-edge
- START  in  1  request; sampled only while BUSY=0
- OP  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  in  32  rs1 operand (register-file RD1)
- B  in  32  rs2 operand (register-file RD2)
- DST  in  5  destination register index
- BUSY  out  1  high from the cycle after acceptance through the DONE cycle
- DONE  out  1  one-cycle pulse; RESULT and WDA_OUT are valid in this cycle
- RESULT  out  32  result for the write port (WD)
- WDA_OUT  out  5  latched DST (WDA)
- WE_OUT  out  1  equals DONE & (WDA_OUT != 0)

Behaviour:
- Reset: RESET is asynchronous and active-high; clock is CLK. RESET forces state IDLE and clears BUSY, DONE, WE_OUT, RESULT, WDA_OUT, the counter and all datapath registers to 0.
- Reset mid-operation: the operation is abandoned; no DONE is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - With START=1 at a rising edge, latch OP, DST, operand magnitudes and result sign.
  - Go to RUN with counter=0, unless a special case applies (see below), in which case go straight to FIN with the result preloaded.
  - START=0: stay in IDLE.
- RUN: one iteration per cycle. At counter=31, go to FIN; otherwise increment the counter.
- FIN: DONE=1 and BUSY=1 for exactly one cycle, then go to IDLE.
- START while BUSY=1 is ignored (not queued).
- Latency (START high in cycle 0):
  - Normal operation: BUSY high in cycles 1..33, DONE in cycle 33, next START accepted in cycle 34.
  - Special case: DONE in cycle 1.
- Multiply:
  - Shift-add over unsigned magnitudes into a 64-bit accumulator. Negate the 64-bit result if the operand signs differ.
  - Operand signedness: MULH treats A and B as signed; MULHSU treats A signed, B unsigned; MULHU and MUL treat both as unsigned.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring shift-subtract over magnitudes.
  - Quotient is negated if the signs of A and B differ (signed ops only).
  - Remainder takes the sign of A (signed ops only).
- Special cases (resolved in IDLE, no iterations):
  - B=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return A.
  - DIV with A=0x80000000, B=0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
- RESULT and WDA_OUT hold their last values after DONE until the next completion; only DONE and WE_OUT pulse.
- A, B and DST may change after the acceptance edge without effect.

Test Plan:
- MUL, A=7, B=-3 (0xFFFFFFFD), DST=5 -> DONE in cycle 33, RESULT=0xFFFFFFEB, WDA_OUT=5, WE_OUT=1, BUSY high in cycles 1..33.
- MULH, A=B=0x80000000 -> RESULT=0x40000000. MULHU, A=B=0xFFFFFFFF -> RESULT=0xFFFFFFFE. MULHSU, A=0xFFFFFFFF, B=0xFFFFFFFF -> RESULT=0xFFFFFFFF.
- DIV, A=-7, B=2 -> RESULT=0xFFFFFFFD (-3). REM, A=-7, B=2 -> RESULT=0xFFFFFFFF (-1). DIVU, A=100, B=7 -> RESULT=14. REMU, A=100, B=7 -> RESULT=2.
- DIVU with B=0 -> RESULT=0xFFFFFFFF with DONE in cycle 1. REMU, A=0x1234, B=0 -> RESULT=0x1234. DIV, A=0x80000000, B=0xFFFFFFFF -> RESULT=0x80000000 with DONE in cycle 1.
- Second START pulse in cycle 10 with different operands -> ignored: exactly one DONE, in cycle 33, carrying the first result. DST=0 -> DONE=1 with WE_OUT=0.
- RESET asserted in cycle 15 of a DIV -> BUSY and DONE go to 0 immediately (asynchronously). No DONE follows. A new START after reset release completes normally.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with a start/busy/done handshake.
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            RESET,
  input  logic            CLK,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      DST,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      WDA_OUT,
  output logic            WE_OUT
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [4:0]       dst_q;
  logic [XLEN-1:0]  hi, lo, ma, mb;
  logic             sq, sr;

  logic            last;
  logic            sgn_a, sgn_b;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            ovf, spec;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]     msum;
  logic [XLEN:0]     dsh;
  logic [XLEN-1:0]   dsub;
  logic              ge;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   q_s, r_s, fin_res;

  assign last = (cnt == CNT_W'(XLEN-1));

  // Operand conditioning at acceptance
  assign sgn_a = (OP == 3'b001) | (OP == 3'b010) |
                 (OP == 3'b100) | (OP == 3'b110);
  assign sgn_b = (OP == 3'b001) | (OP == 3'b100) |
                 (OP == 3'b110);
  assign a_neg = sgn_a & A[XLEN-1];
  assign b_neg = sgn_b & B[XLEN-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign ovf   = ((OP == 3'b100) | (OP == 3'b110)) &
                 (A == MINV) & (B == '1);

  always_comb begin
    spec     = 1'b0;
    spec_res = '0;
    if (OP[2] && (B == '0)) begin
      spec     = 1'b1;
      spec_res = OP[1] ? A : '1;
    end else if (ovf) begin
      spec     = 1'b1;
      spec_res = OP[1] ? '0 : MINV;
    end
  end

  // One iteration step; mul keeps the multiplier in lo,
  // div keeps the dividend/quotient in lo and remainder in hi.
  assign msum = {1'b0, hi} + (lo[0] ? {1'b0, ma} : '0);
  assign dsh  = {hi, lo[XLEN-1]};
  assign ge   = (dsh >= {1'b0, mb});
  assign dsub = dsh[XLEN-1:0] - mb;

  always_comb begin
    hi_n = msum[XLEN:1];
    lo_n = {msum[0], lo[XLEN-1:1]};
    if (op_q[2]) begin
      hi_n = ge ? dsub : dsh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ge};
    end
  end

  assign prod   = {hi_n, lo_n};
  assign prod_s = sq ? -prod : prod;
  assign q_s    = sq ? -lo_n : lo_n;
  assign r_s    = sr ? -hi_n : hi_n;

  always_comb begin
    fin_res = r_s;
    case (op_q)
      3'b000:                 fin_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = q_s;
      default:                fin_res = r_s;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (START) state_n = spec ? FIN : RUN;
      RUN:  if (last)  state_n = FIN;
      FIN:             state_n = IDLE;
      default:         state_n = IDLE;
    endcase
  end

  assign BUSY   = (state != IDLE);
  assign DONE   = (state == FIN);
  assign WE_OUT = DONE & (WDA_OUT != 5'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      hi      <= '0;
      lo      <= '0;
      ma      <= '0;
      mb      <= '0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      RESULT  <= '0;
      WDA_OUT <= '0;
    end else begin
      if (state == IDLE && START) begin
        op_q  <= OP;
        dst_q <= DST;
        cnt   <= '0;
        sq    <= a_neg ^ b_neg;
        sr    <= a_neg;
        if (spec) begin
          RESULT  <= spec_res;
          WDA_OUT <= DST;
        end else begin
          ma <= a_mag;
          mb <= b_mag;
          hi <= '0;
          lo <= OP[2] ? a_mag : b_mag;
        end
      end else if (state == RUN) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          RESULT  <= fin_res;
          WDA_OUT <= dst_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized self-checking bench for mdu_iterative against an
// arithmetic reference model.
module tb_mdu_iterative;

  logic        RESET, CLK, START;
  logic [2:0]  OP;
  logic [31:0] A, B;
  logic [4:0]  DST;
  logic        BUSY, DONE, WE_OUT;
  logic [31:0] RESULT;
  logic [4:0]  WDA_OUT;

  int checks = 0;
  int errors = 0;

  mdu_iterative dut (
    .RESET(RESET), .CLK(CLK), .START(START),
    .OP(OP), .A(A), .B(B), .DST(DST),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .WDA_OUT(WDA_OUT), .WE_OUT(WE_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (op[2] && b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) &&
           a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic run_op(input logic [2:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0]  dst,
                        input bit          poke);
    logic [31:0] exp;
    int lat, n;
    exp = ref_res(op, a, b);
    lat = is_special(op, a, b) ? 1 : 33;
    @(negedge CLK);
    OP = op; A = a; B = b; DST = dst; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    A = $urandom; B = $urandom; DST = 5'($urandom);
    n = 1;
    while (!DONE && n < 40) begin
      check("busy", 32'(BUSY), 32'd1);
      if (poke && n == 10) begin
        START = 1'b1;
        OP = 3'($urandom); A = $urandom; B = $urandom;
      end
      if (n == 11) START = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("done_busy", 32'(BUSY), 32'd1);
    check("result", RESULT, exp);
    check("wda", 32'(WDA_OUT), 32'(dst));
    check("we", 32'(WE_OUT), 32'(dst != 0));
    @(posedge CLK); #1;
    check("post_done", 32'(DONE), 32'd0);
    check("post_busy", 32'(BUSY), 32'd0);
    check("post_we", 32'(WE_OUT), 32'd0);
    check("hold", RESULT, exp);
  endtask

  task automatic reset_mid_op();
    int seen;
    @(negedge CLK);
    OP = 3'd4; A = 32'd1000; B = 32'd7; DST = 5'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(posedge CLK); #1;
    end
    #3 RESET = 1'b1;
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_res", RESULT, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (DONE) seen++;
    end
    check("no_done", 32'(seen), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0;
    OP = '0; A = '0; B = '0; DST = '0;
    #12;
    check("rst_busy0", 32'(BUSY), 32'd0);
    check("rst_done0", 32'(DONE), 32'd0);
    check("rst_we0", 32'(WE_OUT), 32'd0);
    check("rst_res0", RESULT, 32'd0);
    check("rst_wda0", 32'(WDA_OUT), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0);
    run_op(3'd5, 32'd55, 32'd0, 5'd9, 1'b0);
    run_op(3'd7, 32'h1234, 32'd0, 5'd10, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op(3'd0, 32'd123, 32'd456, 5'd13, 1'b1);
    run_op(3'd4, 32'd99, 32'hFFFF_FFF6, 5'd0, 1'b0);

    reset_mid_op();
    run_op(3'd4, 32'd1000, 32'd7, 5'd3, 1'b0);

    for (int i = 0; i < 48; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 300));
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom), 1'(i % 5 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
